// File: rtl/multi_voice_mixer.sv
// N-voice gathered, gain-weighted, saturating sample mixer with a master fade ramp.
// One mix per generate_next_sample request; slow voices time out and reuse their held sample.
module multi_voice_mixer #(
   parameter int NUM_VOICES   = 4,
   parameter int SAMPLE_WIDTH = 16,
   parameter int GAIN_WIDTH   = 8,
   parameter int TIMEOUT      = 255,
   parameter int RAMP_STEP    = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_VOICES-1:0]                voice_en,
   input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0]   sample_in,
   input  logic [NUM_VOICES-1:0]                sample_ready,
   input  logic [NUM_VOICES*GAIN_WIDTH-1:0]     gain,
   input  logic                                 mute,
   input  logic                                 generate_next_sample,
   output logic signed [SAMPLE_WIDTH-1:0]       mixed_sample,
   output logic                                 mixed_ready,
   output logic                                 clip,
   output logic [NUM_VOICES-1:0]                missed,
   output logic                                 overrun,
   output logic                                 busy
);

   localparam int TERM_W   = SAMPLE_WIDTH + 1;
   localparam int PROD_W   = SAMPLE_WIDTH + GAIN_WIDTH + 1;
   localparam int ACC_W    = SAMPLE_WIDTH + 1 + $clog2(NUM_VOICES);
   localparam int CNT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam int LVL_W    = 9;
   localparam int LVL_FULL = 256;
   localparam int MIX_W    = SAMPLE_WIDTH + LVL_W + 1;

   localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic signed [ACC_W-1:0] ACC_MAX =
      {{(ACC_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN =
      {{(ACC_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_SCALE, S_SUM, S_OUT} state_t;

   state_t                         state, state_nxt;
   logic signed [SAMPLE_WIDTH-1:0] hold [NUM_VOICES];
   logic [NUM_VOICES-1:0]          mask, got, missed_p0;
   logic [CNT_W-1:0]               cnt;
   logic [LVL_W-1:0]               level, level_new;
   logic signed [TERM_W-1:0]       term_p1 [NUM_VOICES];
   logic signed [ACC_W-1:0]        acc;
   logic signed [SAMPLE_WIDTH-1:0] sat_p2;
   logic                           clip_p2;
   logic                           collect_done;

   // Q1.(GAIN_WIDTH-1) gain, arithmetic shift floors toward -inf
   function automatic logic signed [TERM_W-1:0] scale_term(
      input logic signed [SAMPLE_WIDTH-1:0] s,
      input logic [GAIN_WIDTH-1:0]          g
   );
      logic signed [PROD_W-1:0] s_x, g_x, prod, shifted;
      s_x     = PROD_W'(s);
      g_x     = PROD_W'($signed({1'b0, g}));
      prod    = s_x * g_x;
      shifted = prod >>> (GAIN_WIDTH - 1);
      return shifted[TERM_W-1:0];
   endfunction

   function automatic logic is_clipped(input logic signed [ACC_W-1:0] a);
      return (a > ACC_MAX) || (a < ACC_MIN);
   endfunction

   function automatic logic signed [SAMPLE_WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] a);
      if (a > ACC_MAX)      return ACC_MAX[SAMPLE_WIDTH-1:0];
      else if (a < ACC_MIN) return ACC_MIN[SAMPLE_WIDTH-1:0];
      else                  return a[SAMPLE_WIDTH-1:0];
   endfunction

   function automatic logic [LVL_W-1:0] ramp_level(input logic [LVL_W-1:0] lv, input logic m);
      int nxt;
      if (m) begin
         nxt = int'(lv) - RAMP_STEP;
         if (nxt < 0) nxt = 0;
      end else begin
         nxt = int'(lv) + RAMP_STEP;
         if (nxt > LVL_FULL) nxt = LVL_FULL;
      end
      return LVL_W'(nxt);
   endfunction

   // level 256 is exactly unity after the >>> 8
   function automatic logic signed [SAMPLE_WIDTH-1:0] apply_level(
      input logic signed [SAMPLE_WIDTH-1:0] s,
      input logic [LVL_W-1:0]               lv
   );
      logic signed [MIX_W-1:0] s_x, l_x, prod, shifted;
      s_x     = MIX_W'(s);
      l_x     = MIX_W'($signed({1'b0, lv}));
      prod    = s_x * l_x;
      shifted = prod >>> 8;
      return shifted[SAMPLE_WIDTH-1:0];
   endfunction

   assign collect_done = ((got & mask) == mask) || (cnt == CNT_MAX);
   assign level_new    = ramp_level(level, mute);
   assign busy         = (state != S_IDLE);

   always_comb begin
      acc = '0;
      for (int i = 0; i < NUM_VOICES; i++) acc = acc + ACC_W'(term_p1[i]);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (generate_next_sample) state_nxt = (voice_en == '0) ? S_SCALE : S_COLLECT;
         S_COLLECT: if (collect_done) state_nxt = S_SCALE;
         S_SCALE:   state_nxt = S_SUM;
         S_SUM:     state_nxt = S_OUT;
         S_OUT:     state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_IDLE;
         mask         <= '0;
         got          <= '0;
         missed_p0    <= '0;
         cnt          <= '0;
         level        <= '0;
         mixed_sample <= '0;
         mixed_ready  <= 1'b0;
         clip         <= 1'b0;
         missed       <= '0;
         overrun      <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) hold[i] <= '0;
      end else begin
         state       <= state_nxt;
         mixed_ready <= 1'b0;
         clip        <= 1'b0;
         overrun     <= generate_next_sample && (state != S_IDLE);
         for (int i = 0; i < NUM_VOICES; i++)
            if (sample_ready[i]) hold[i] <= sample_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
         case (state)
            S_IDLE: if (generate_next_sample) begin
               mask      <= voice_en;
               got       <= sample_ready;
               cnt       <= '0;
               missed_p0 <= '0;
            end
            // stage p0: gather ready voices until complete or timed out
            S_COLLECT: begin
               got <= got | sample_ready;
               if (collect_done) missed_p0 <= mask & ~got;
               else              cnt       <= cnt + CNT_W'(1);
            end
            S_OUT: begin
               level        <= level_new;
               mixed_sample <= apply_level(sat_p2, level_new);
               mixed_ready  <= 1'b1;
               clip         <= clip_p2;
               missed       <= missed_p0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // stage p1: per-voice gain
      if (state == S_SCALE)
         for (int i = 0; i < NUM_VOICES; i++)
            term_p1[i] <= mask[i] ? scale_term(hold[i], gain[i*GAIN_WIDTH +: GAIN_WIDTH]) : '0;
      // stage p2: saturating sum
      if (state == S_SUM) begin
         sat_p2  <= saturate(acc);
         clip_p2 <= is_clipped(acc);
      end
   end

endmodule

// File: doc/multi_voice_mixer.md
Name: multi_voice_mixer

Overview:
Parametrised N-voice sample mixer. It sits between the per-voice note generators (chords, harmonic player, ADSR path) and codec_conditioner. It replaces the fixed song-based sample mux with a gathered, gain-weighted, saturating sum. A master fade ramp removes clicks on mute and unmute. One mix is produced for each generate_next_sample request, with per-voice timeout and hold-last behaviour.

Parameters:
NUM_VOICES, 4, number of input voices (1..8).
SAMPLE_WIDTH, 16, signed two's-complement sample width.
GAIN_WIDTH, 8, unsigned per-voice gain width. Format is Q1.(GAIN_WIDTH-1), so 2^(GAIN_WIDTH-1) is unity gain.
TIMEOUT, 255, maximum number of COLLECT cycles to wait for enabled voices.
RAMP_STEP, 16, master-level step per output sample. Master level full scale is 256.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset: the block resets on a rising clk edge while reset==0
voice_en  in  NUM_VOICES  per-voice enable
sample_in  in  NUM_VOICES*SAMPLE_WIDTH  voice samples, voice i at bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
sample_ready  in  NUM_VOICES  one-cycle per-voice sample-valid pulse
gain  in  NUM_VOICES*GAIN_WIDTH  per-voice gain, packed the same way as sample_in
mute  in  1  level; when high, the master level ramps toward 0
generate_next_sample  in  1  one-cycle request from codec_conditioner
mixed_sample  out  SAMPLE_WIDTH  mixed output, held between updates
mixed_ready  out  1  one-cycle pulse when mixed_sample updates
clip  out  1  one-cycle pulse, coincident with mixed_ready, when saturation occurred
missed  out  NUM_VOICES  per-voice flags, valid with mixed_ready: the voice timed out and its held sample was reused
overrun  out  1  one-cycle pulse when generate_next_sample arrives while the block is not in IDLE
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, all hold registers=0, got=0, timeout counter=0, master level=0.
  - Outputs after reset: mixed_sample=0, mixed_ready=0, clip=0, missed=0, overrun=0, busy=0.
  - Reset mid-operation aborts the mix with no output pulse. After reset the block fades in from level 0.
- Hold registers: hold[i] loads sample_in[i] on any cycle where sample_ready[i]=1, regardless of state.
- FSM: IDLE -> COLLECT -> SCALE -> SUM -> OUT -> IDLE.
- IDLE:
  - On generate_next_sample: latch mask=voice_en, clear got, clear the timeout counter, then go to COLLECT.
  - A sample_ready[i] in the same cycle as the request sets got[i].
  - If mask==0, go directly to SCALE; all terms are 0.
- COLLECT:
  - sample_ready[i] sets got[i].
  - Exit to SCALE in the cycle after (got & mask)==mask, or when the counter reaches TIMEOUT.
  - On exit, missed = mask & ~got. Missed voices use their last held value (hold-last, not zero).
- SCALE:
  - term[i] = mask[i] ? (signed hold[i] * {1'b0,gain[i]}) >>> (GAIN_WIDTH-1) : 0.
  - Arithmetic shift, truncating toward -inf.
- SUM:
  - acc = sum of terms, width SAMPLE_WIDTH+1+clog2(NUM_VOICES), no wrap.
  - Saturate to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1]; set clip_int if saturation occurred.
- OUT:
  - Master level update: step toward target (0 if mute, else 256) by RAMP_STEP, clamped at the target.
  - mixed_sample = (sat * level_new) >>> 8, so level 256 passes sat exactly.
  - Pulse mixed_ready, and pulse clip if clip_int.
- Latency:
  - Last needed ready at cycle t gives mixed_ready at t+4 (exit COLLECT at t+1, SCALE t+2, SUM t+3, OUT t+4).
  - Timeout path: mixed_ready TIMEOUT+4 cycles after the request.
- generate_next_sample while busy: ignored (no queueing) and overrun pulses.
- voice_en changes during COLLECT are ignored; the mask is latched at the request.
- gain=0 gives term 0. Maximum gain (2^GAIN_WIDTH-1) at full-scale input must saturate, not wrap.

Test Plan:
- 2 voices enabled, gain 0x80, samples 1000 and -300 ready 2 cycles after the request -> mixed_sample=700, mixed_ready exactly 4 cycles after the last ready, clip=0.
- 4 voices, each 0x7000 at gain 0x80 -> mixed_sample=0x7FFF, clip=1. Same test with each -0x7000 -> 0x8000, clip=1.
- Voice 2 enabled but never ready, previously held 0x0400, gain 0x40; other voices 0 -> after TIMEOUT+4 cycles, mixed_sample=0x0200 and missed=4'b0100.
- Unmuted steady input 8000 at unity, then mute=1 -> outputs step down 7500, 7000, … to 0 over 16 samples. Release mute -> ramp back up to 8000.
- Second generate_next_sample during COLLECT -> overrun pulses once and only one mixed_ready occurs. reset=0 during SUM -> no mixed_ready, all outputs 0 on the next cycle.
- voice_en=0 on request -> mixed_ready 3 cycles after the request (IDLE->SCALE->SUM->OUT) with mixed_sample=0, missed=0.
